bcd_stopwatch_counter: RTL and testbench

- Three-digit BCD up/down seconds counter.
- Produces the ones/tens/hundreds digit nibbles that the multiplexed 7-segment display stage consumes.
- Derives its count tick from the 100 MHz board clock through an internal prescaler.
- Provides start/stop/clear/load control and a one-cycle expiry pulse for the processor or LEDs.

---
 rtl/bcd_stopwatch_counter_pkg.sv | 31 +++
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_stopwatch_counter.sv | 139 +++++++++++++
 tb/tb_bcd_stopwatch_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared stopwatch definitions: state encoding, BCD limits and count-direction codes.
// Reused by the display stage and the processor I/O block.
package bcd_stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

  // Count already sitting at the end value for the given direction.
  function automatic logic bcd_is_terminal(input logic [11:0] bcd, input logic d);
    return (d == DIR_UP) ? (bcd == 12'h999) : (bcd == 12'h000);
  endfunction

  // Count one step away from the end value, so the next tick lands on it.
  function automatic logic bcd_pre_terminal(input logic [11:0] bcd, input logic d);
    return (d == DIR_UP) ? (bcd == 12'h998) : (bcd == 12'h001);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit up/down counter with clamped parallel load; carry_out flags a wrap.
// Load takes priority over enable; carry_out is combinational so digits chain in one cycle.
module bcd_digit
  import bcd_stopwatch_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_d,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] q_r;

  assign q = q_r;
  assign carry_out = en && ((dir == DIR_UP) ? (q_r >= BCD_MAX_DIGIT) : (q_r == 4'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 4'd0;
    end else if (load) begin
      q_r <= bcd_clamp(load_d);
    end else if (en) begin
      if (dir == DIR_UP) begin
        q_r <= (q_r >= BCD_MAX_DIGIT) ? 4'd0 : q_r + 4'd1;
      end else begin
        q_r <= (q_r == 4'd0) ? BCD_MAX_DIGIT : q_r - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Three-digit BCD up/down seconds counter with prescaled tick, start/stop/clear/load control
// and a one-cycle expiry pulse; all outputs registered.
module bcd_stopwatch_counter
  import bcd_stopwatch_counter_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int PRESCALE_W = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        dir,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic        running,
  output logic        expired
);

  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);

  sw_state_t             state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  dir_q, dir_d;
  logic                  running_q, expired_q, expired_d;

  logic                  tick;
  logic                  cnt_en;
  logic                  dig_load;
  logic [11:0]           dig_load_val;
  logic [11:0]           count;
  logic                  ones_co, tens_co, hund_co;

  assign count = {hundreds, tens, ones};
  assign tick  = (state_q == ST_RUN) && (presc_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      dir_q     <= DIR_UP;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    dir_d        = dir_q;
    expired_d    = 1'b0;
    cnt_en       = 1'b0;
    dig_load     = 1'b0;
    dig_load_val = load_val;

    if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (clear) begin
      state_d      = ST_IDLE;
      presc_d      = '0;
      dig_load     = 1'b1;
      dig_load_val = 12'h000;
    end else if (load && (state_q != ST_RUN)) begin
      dig_load = 1'b1;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_RUN) begin
      // A tick that coincides with stop still counts; reaching the end value beats the pause.
      cnt_en = tick;
      if (tick && (bcd_pre_terminal(count, dir_q) || hund_co)) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else if (stop) begin
        state_d = ST_PAUSE;
      end
    end else if (start && !stop) begin
      dir_d = dir;
      if (state_q != ST_PAUSE) begin
        presc_d = '0;
      end
      if (bcd_is_terminal(count, dir)) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  bcd_digit u_ones (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .dir       (dir_q),
    .load      (dig_load),
    .load_d    (dig_load_val[3:0]),
    .q         (ones),
    .carry_out (ones_co)
  );

  bcd_digit u_tens (
    .clk       (clk),
    .rst       (rst),
    .en        (ones_co),
    .dir       (dir_q),
    .load      (dig_load),
    .load_d    (dig_load_val[7:4]),
    .q         (tens),
    .carry_out (tens_co)
  );

  bcd_digit u_hundreds (
    .clk       (clk),
    .rst       (rst),
    .en        (tens_co),
    .dir       (dir_q),
    .load      (dig_load),
    .load_d    (dig_load_val[11:8]),
    .q         (hundreds),
    .carry_out (hund_co)
  );

  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed-vector bench for bcd_stopwatch_counter with TICK_DIV=4.
module tb_bcd_stopwatch_counter;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, load, dir;
  logic [11:0] load_val;
  logic [3:0]  ones, tens, hundreds;
  logic        running, expired;

  int n_vec = 0;
  int n_bad = 0;
  int pulses;

  always #5 clk = ~clk;

  bcd_stopwatch_counter #(.TICK_DIV(4), .PRESCALE_W(27)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .running  (running),
    .expired  (expired)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n edges and settle just past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1; load_val = v; cyc(1); load = 1'b0;
  endtask

  task automatic do_start(input logic d);
    start = 1'b1; dir = d; cyc(1); start = 1'b0;
  endtask

  function automatic logic [11:0] digs();
    return {hundreds, tens, ones};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    dir = 1'b0; load_val = 12'h000;

    // Reset and idle
    cyc(2); rst = 1'b0;
    chk("rst_digits", digs(), 12'h000);
    chk("rst_running", {11'd0, running}, 12'd0);
    chk("rst_expired", {11'd0, expired}, 12'd0);
    cyc(20);
    chk("idle_digits", digs(), 12'h000);
    chk("idle_running", {11'd0, running}, 12'd0);

    // Up count with carry: 098 -> 099 -> 100
    do_load(12'h098);
    chk("load_098", digs(), 12'h098);
    do_start(1'b0);
    chk("up_running", {11'd0, running}, 12'd1);
    cyc(3);
    chk("up_pre_tick", digs(), 12'h098);
    cyc(1);
    chk("up_099", digs(), 12'h099);
    cyc(4);
    chk("up_100", digs(), 12'h100);
    chk("up_still_running", {11'd0, running}, 12'd1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clear_digits", digs(), 12'h000);
    chk("clear_running", {11'd0, running}, 12'd0);

    // Down with borrow: 100 -> 099
    do_load(12'h100);
    do_start(1'b1);
    cyc(4);
    chk("down_borrow_099", digs(), 12'h099);
    clear = 1'b1; cyc(1); clear = 1'b0;

    // Down expiry: 002 -> 001 -> 000 with a single expired pulse
    do_load(12'h002);
    do_start(1'b1);
    cyc(4);
    chk("down_001", digs(), 12'h001);
    cyc(3);
    chk("down_no_early_exp", {11'd0, expired}, 12'd0);
    cyc(1);
    chk("down_000", digs(), 12'h000);
    chk("down_expired", {11'd0, expired}, 12'd1);
    chk("down_done_running", {11'd0, running}, 12'd0);
    cyc(1);
    chk("down_exp_one_cycle", {11'd0, expired}, 12'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (expired) pulses++;
    end
    chk("done_hold_digits", digs(), 12'h000);
    chk("done_no_more_pulses", 12'(pulses), 12'd0);

    // Pause and resume: stop two edges into the first tick period
    do_load(12'h000);
    do_start(1'b0);
    cyc(1);
    stop = 1'b1; cyc(10); stop = 1'b0;
    chk("pause_digits", digs(), 12'h000);
    chk("pause_running", {11'd0, running}, 12'd0);
    do_start(1'b0);
    chk("resume_running", {11'd0, running}, 12'd1);
    cyc(1);
    chk("resume_not_yet", digs(), 12'h000);
    cyc(1);
    chk("resume_001", digs(), 12'h001);

    // Guards and priority
    do_load(12'h123);
    chk("load_in_run_ignored", digs(), 12'h001);
    chk("load_in_run_running", {11'd0, running}, 12'd1);
    clear = 1'b1; load = 1'b1; load_val = 12'h555; cyc(1); clear = 1'b0; load = 1'b0;
    chk("clear_beats_load", digs(), 12'h000);
    chk("clear_load_idle", {11'd0, running}, 12'd0);
    do_load(12'hFAF);
    chk("load_clamp", digs(), 12'h999);

    // Immediate terminal on start
    do_start(1'b0);
    chk("imm_running", {11'd0, running}, 12'd0);
    chk("imm_expired", {11'd0, expired}, 12'd1);
    chk("imm_digits", digs(), 12'h999);
    cyc(1);
    chk("imm_exp_one_cycle", {11'd0, expired}, 12'd0);
    chk("imm_hold", digs(), 12'h999);

    // Up expiry: 997 -> 998 -> 999
    do_load(12'h997);
    do_start(1'b0);
    cyc(4);
    chk("up_998", digs(), 12'h998);
    chk("up_998_running", {11'd0, running}, 12'd1);
    cyc(4);
    chk("up_999", digs(), 12'h999);
    chk("up_999_expired", {11'd0, expired}, 12'd1);
    chk("up_999_running", {11'd0, running}, 12'd0);

    // Reset mid-count aborts with no pulse
    do_load(12'h050);
    do_start(1'b0);
    cyc(4);
    chk("rst_pre_051", digs(), 12'h051);
    cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("midrst_digits", digs(), 12'h000);
    chk("midrst_running", {11'd0, running}, 12'd0);
    chk("midrst_expired", {11'd0, expired}, 12'd0);
    cyc(5);
    chk("midrst_idle_hold", digs(), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
